rng_debias: RTL and testbench

//  Stage between TRNG and collector. Consumes raw TRNG bits over a READY/ACK handshake.

---
 rtl/rng_pkg.sv | 18 +
 rtl/rng_fifo.sv | 61 ++++++
 rtl/rng_debias.sv | 149 ++++++++++++++
 tb/tb_rng_debias.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and defaults for the von Neumann debiasing stage (rng_debias).
package rng_pkg;

    typedef enum logic [1:0] {
        PAIR_A = 2'd0,
        PAIR_B = 2'd1,
        FAIL   = 2'd2
    } rng_state_e;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_REP_LIMIT  = 32;

    // A raw pair yields an output bit only when its two bits differ.
    function automatic logic pair_valid(input logic first_bit, input logic second_bit);
        return first_bit ^ second_bit;
    endfunction

endpackage

// File: rtl/rng_fifo.sv
// 1-bit-wide corrected-bit buffer with power-of-two depth and synchronous flush.
module rng_fifo
    import rng_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_flush,
    input  logic i_push,
    input  logic i_push_bit,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output logic o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == CW'(0));
    assign o_head  = o_empty ? 1'b0 : r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage, pointers and occupancy; flush discards everything at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_bit;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rng_debias.sv
// Von Neumann debiaser between TRNG and collector with output FIFO.
// Define RNG_HEALTH_EN to enable the repetition-count health test.
module rng_debias
    import rng_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_raw_bit,
    input  logic i_raw_ready,
    output logic o_raw_ack,
    output logic o_random,
    output logic o_bit_ready,
    input  logic i_ack,
    input  logic i_health_clr,
    output logic o_health_fail
);

    rng_state_e r_state;
    logic       r_first;
    logic       r_raw_ack;
    logic       w_accept;
    logic       w_push;
    logic       w_full;
    logic       w_empty;
    logic       w_flush;
    logic       w_trip;

`ifdef RNG_HEALTH_EN
    localparam int RW = $clog2(REP_LIMIT + 1);

    logic [RW-1:0] r_rep_cnt;
    logic [RW-1:0] w_rep_next;
    logic          r_prev;
    logic          r_health_fail;

    // Run length of identical accepted bits, saturating at the limit.
    always_comb begin
        w_rep_next = RW'(1);
        if ((r_rep_cnt != RW'(0)) && (i_raw_bit == r_prev)) begin
            if (r_rep_cnt == RW'(REP_LIMIT)) begin
                w_rep_next = r_rep_cnt;
            end else begin
                w_rep_next = r_rep_cnt + RW'(1);
            end
        end else begin
            w_rep_next = RW'(1);
        end
        w_trip  = w_accept & (w_rep_next == RW'(REP_LIMIT)) & ~i_health_clr;
        w_flush = w_trip | (r_state == FAIL);
    end

    // Repetition counter and sticky failure flag; clear wins over a trip.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rep_cnt     <= '0;
            r_prev        <= 1'b0;
            r_health_fail <= 1'b0;
        end else if (i_health_clr) begin
            r_rep_cnt     <= '0;
            r_prev        <= r_prev;
            r_health_fail <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rep_cnt <= w_rep_next;
                r_prev    <= i_raw_bit;
            end
            if (w_trip) begin
                r_health_fail <= 1'b1;
            end
        end
    end

    assign o_health_fail = r_health_fail;
`else
    logic w_unused_health_clr;

    assign w_unused_health_clr = i_health_clr;
    assign w_trip              = 1'b0;
    assign w_flush             = 1'b0;
    assign o_health_fail       = 1'b0;
`endif

    // Accept needs a gap cycle after each ACK so one READY is never consumed twice.
    always_comb begin
        w_accept = i_en & i_raw_ready & ~r_raw_ack & ~w_full & (r_state != FAIL);
        w_push   = w_accept & (r_state == PAIR_B) & pair_valid(r_first, i_raw_bit);
    end

    // Pairing FSM and raw-side handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= PAIR_A;
            r_first   <= 1'b0;
            r_raw_ack <= 1'b0;
        end else begin
            r_raw_ack <= w_accept;
`ifdef RNG_HEALTH_EN
            if (i_health_clr) begin
                r_state <= PAIR_A;
            end else if (w_trip) begin
                r_state <= FAIL;
            end else
`endif
            begin
                case (r_state)
                    PAIR_A: begin
                        if (w_accept) begin
                            r_first <= i_raw_bit;
                            r_state <= PAIR_B;
                        end else begin
                            r_state <= PAIR_A;
                        end
                    end
                    PAIR_B: begin
                        if (!i_en || w_accept) begin
                            r_state <= PAIR_A;
                        end else begin
                            r_state <= PAIR_B;
                        end
                    end
                    FAIL:    r_state <= FAIL;
                    default: r_state <= PAIR_A;
                endcase
            end
        end
    end

    rng_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_flush    (w_flush),
        .i_push     (w_push),
        .i_push_bit (r_first),
        .i_pop      (i_ack),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_head     (o_random)
    );

    assign o_raw_ack   = r_raw_ack;
    assign o_bit_ready = ~w_empty;

endmodule

// File: tb/tb_rng_debias.sv
// Scoreboard bench for rng_debias: random and directed raw streams against a pair-list model.
module tb_rng_debias;

    logic clk = 1'b0;
    logic rst_n, en, raw_bit, raw_ready, raw_ack, random_bit, bit_ready;
    logic ack, health_clr, health_fail;

    int   checks = 0;
    int   errors = 0;
    int   ack_cnt = 0;
    int   coll_once = 0;
    bit   coll_en = 1'b0;
    bit   exp_q[$];
    bit   pair_buf[$];

    always #5 clk = ~clk;

    rng_debias #(.FIFO_DEPTH(4), .REP_LIMIT(32)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_raw_bit    (raw_bit),
        .i_raw_ready  (raw_ready),
        .o_raw_ack    (raw_ack),
        .o_random     (random_bit),
        .o_bit_ready  (bit_ready),
        .i_ack        (ack),
        .i_health_clr (health_clr),
        .o_health_fail(health_fail)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: collect accepted raw bits two at a time; unequal pairs emit the first bit.
    function automatic void model_accept(input bit b);
        pair_buf.push_back(b);
        if (pair_buf.size() == 2) begin
            if (pair_buf[0] != pair_buf[1]) exp_q.push_back(pair_buf[0]);
            pair_buf.delete();
        end
    endfunction

    always @(negedge clk) if (raw_ack) ack_cnt++;

    // Collector and scoreboard monitor: pops one entry per ACK pulse.
    always @(negedge clk) begin
        if (ack) begin
            ack = 1'b0;
        end else if (bit_ready && (coll_once > 0 || (coll_en && $urandom_range(0, 1) == 1))) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bit: got %0d expected none", random_bit);
            end else begin
                chk("random", 32'(random_bit), 32'(exp_q.pop_front()));
            end
            ack = 1'b1;
            if (coll_once > 0) coll_once--;
        end
    end

    task automatic send_bit(input bit b, input int budget, output bit ok);
        raw_bit   = b;
        raw_ready = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (raw_ack) ok = 1'b1;
        end
        if (ok) begin
            raw_ready = 1'b0;
            model_accept(b);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        coll_en = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bit_ready && !ack) done = 1'b1;
        end
        chk("drain_bit_ready", 32'(bit_ready), 32'd0);
        chk("drain_queue_left", 32'(exp_q.size()), 32'd0);
        coll_en = 1'b0;
    endtask

    task automatic drop_en();
        en = 1'b0;
        pair_buf.delete();
        repeat (2) @(negedge clk);
        en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int start, acc, more;
        rst_n = 1'b0; en = 1'b0; raw_bit = 1'b0; raw_ready = 1'b0;
        ack = 1'b0; health_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_raw_ack", 32'(raw_ack), 32'd0);
        chk("rst_bit_ready", 32'(bit_ready), 32'd0);
        chk("rst_random", 32'(random_bit), 32'd0);
        chk("rst_health_fail", 32'(health_fail), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;

        // Pairs 0,1 then 1,0: output appears with the second ACK of each pair.
        start = ack_cnt;
        send_bit(1'b0, 20, ok); chk("p01_first_ack", 32'(ok), 32'd1);
        chk("p01_half_empty", 32'(bit_ready), 32'd0);
        send_bit(1'b1, 20, ok); chk("p01_second_ack", 32'(ok), 32'd1);
        chk("p01_latency", 32'(bit_ready), 32'd1);
        drain();
        send_bit(1'b1, 20, ok); chk("p10_half_empty", 32'(bit_ready), 32'd0);
        send_bit(1'b0, 20, ok); chk("p10_latency", 32'(bit_ready), 32'd1);
        drain();
        chk("p01_p10_raw_acks", 32'(ack_cnt - start), 32'd4);

        // 0,0,1,1 produces nothing.
        start = ack_cnt;
        send_bit(1'b0, 20, ok); send_bit(1'b0, 20, ok);
        send_bit(1'b1, 20, ok); send_bit(1'b1, 20, ok);
        repeat (3) @(negedge clk);
        chk("equal_pairs_empty", 32'(bit_ready), 32'd0);
        chk("equal_pairs_acks", 32'(ack_cnt - start), 32'd4);

        // EN drop discards the stray first bit.
        send_bit(1'b0, 20, ok);
        drop_en();
        send_bit(1'b1, 20, ok);
        chk("en_drop_no_stray", 32'(bit_ready), 32'd0);
        send_bit(1'b0, 20, ok);
        chk("en_drop_push", 32'(bit_ready), 32'd1);
        drain();

        // Random stream with random EN drops and random collector pacing.
        coll_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) drop_en();
            send_bit(1'($urandom_range(0, 1)), 200, ok);
            if (!ok) chk("rand_accept", 32'(ok), 32'd1);
        end
        drain();
        drop_en();

        // FIFO full back-pressure: 4 pushes then RAW_ACK stops; one pop admits one pair.
        acc = 0;
        for (int k = 0; k < 20 && acc >= k; k++) begin
            send_bit(1'((k % 2) == 0), 10, ok);
            if (ok) acc++;
        end
        chk("full_accepted_bits", 32'(acc), 32'd8);
        chk("full_no_ack", 32'(raw_ack), 32'd0);
        chk("full_bit_ready", 32'(bit_ready), 32'd1);
        coll_once = 1;
        more = 0;
        for (int k = 8; k < 20 && (more + 8) >= k; k++) begin
            send_bit(1'((k % 2) == 0), 10, ok);
            if (ok) more++;
        end
        chk("full_one_pop_pair", 32'(more), 32'd2);

        // Async reset with a full FIFO and a pending raw bit.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_raw_ack", 32'(raw_ack), 32'd0);
        chk("async_rst_bit_ready", 32'(bit_ready), 32'd0);
        chk("async_rst_random", 32'(random_bit), 32'd0);
        chk("async_rst_health", 32'(health_fail), 32'd0);
        raw_ready = 1'b0;
        exp_q.delete();
        pair_buf.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_bit(1'b1, 20, ok); send_bit(1'b0, 20, ok);
        chk("post_rst_push", 32'(bit_ready), 32'd1);
        drain();

`ifdef RNG_HEALTH_EN
        // Health test: 32 identical bits trip the failure and block the source.
        drop_en();
        send_bit(1'b0, 20, ok);
        acc = 0;
        for (int k = 0; k < 32; k++) begin
            send_bit(1'b1, 20, ok);
            if (ok) acc++;
        end
        chk("health_ones_accepted", 32'(acc), 32'd32);
        chk("health_fail_set", 32'(health_fail), 32'd1);
        exp_q.delete();
        pair_buf.delete();
        send_bit(1'b1, 10, ok);
        chk("health_blocked", 32'(ok), 32'd0);
        chk("health_flushed", 32'(bit_ready), 32'd0);
        raw_ready = 1'b0;
        health_clr = 1'b1;
        @(negedge clk);
        health_clr = 1'b0;
        chk("health_cleared", 32'(health_fail), 32'd0);
        send_bit(1'b1, 20, ok); send_bit(1'b0, 20, ok);
        chk("health_resume", 32'(bit_ready), 32'd1);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
